// File: rtl/uart_axil_apb_bridge.sv
// AXI4-Lite slave to APB master bridge for the chipset UART: one outstanding
// transfer, fair read/write arbitration and an APB wait-state timeout.
//
// state  | meaning
// IDLE   | accepting AW/W/AR into holding buffers, granting when a request is complete
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting on pready or timeout
// WRESP  | write response presented, waiting on bready
// RRESP  | read response presented, waiting on rready
module uart_axil_apb_bridge #(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    chipset_clk,
  input  logic                    chipset_rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_t;

  state_t                  state, state_nxt;
  logic                    aw_held, w_held, ar_held;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STRB_WIDTH-1:0]   w_strb;
  logic                    last_was_write;
  logic [CNT_WIDTH-1:0]    wait_cnt;
  logic                    grant_write;
  logic                    wr_pend, rd_pend;
  logic                    timeout, access_done;
  logic [1:0]              xfer_resp;

  assign wr_pend     = aw_held & w_held;
  assign rd_pend     = ar_held;
  assign timeout     = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_VAL);
  // pready wins over an expiring timeout in the same cycle
  assign access_done = pready | timeout;
  assign xfer_resp   = (pready && !pslverr) ? 2'b00 : 2'b10;

  assign s_axi_awready = (state == IDLE) & ~aw_held;
  assign s_axi_wready  = (state == IDLE) & ~w_held;
  assign s_axi_arready = (state == IDLE) & ~ar_held;
  assign psel          = (state == SETUP) | (state == ACCESS);
  assign penable       = (state == ACCESS);
  assign s_axi_bvalid  = (state == WRESP);
  assign s_axi_rvalid  = (state == RRESP);

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_write = 1'b0;
    case (state)
      IDLE: begin
        if (wr_pend || rd_pend) begin
          state_nxt   = SETUP;
          grant_write = wr_pend & (~rd_pend | ~last_was_write);
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (access_done) state_nxt = pwrite ? WRESP : RRESP;
      WRESP:  if (s_axi_bready) state_nxt = IDLE;
      RRESP:  if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      ar_held <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end else if (state == ACCESS && access_done && pwrite) begin
        aw_held <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (state == ACCESS && access_done && pwrite) begin
        w_held <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        ar_held <= 1'b1;
        ar_addr <= s_axi_araddr;
      end else if (state == ACCESS && access_done && !pwrite) begin
        ar_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      pwrite         <= 1'b0;
      paddr          <= '0;
      pwdata         <= '0;
      pstrb          <= '0;
      last_was_write <= 1'b0;
      wait_cnt       <= '0;
      s_axi_bresp    <= 2'b00;
      s_axi_rresp    <= 2'b00;
      s_axi_rdata    <= '0;
    end else begin
      if (state == IDLE && state_nxt == SETUP) begin
        pwrite         <= grant_write;
        paddr          <= grant_write ? aw_addr : ar_addr;
        pwdata         <= grant_write ? w_data : '0;
        pstrb          <= grant_write ? w_strb : '0;
        last_was_write <= grant_write;
      end
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !pready)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == ACCESS && access_done) begin
        if (pwrite) begin
          s_axi_bresp <= xfer_resp;
        end else begin
          s_axi_rresp <= xfer_resp;
          s_axi_rdata <= pready ? prdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_axil_apb_bridge.sv
// Directed plus randomized bench for uart_axil_apb_bridge; expected APB phases,
// latencies and responses come from a transaction-level model of the bridge rules.
module tb_uart_axil_apb_bridge;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          chipset_clk, chipset_rst_n;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr, paddr;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata, pwdata, prdata;
  logic [SW-1:0] s_axi_wstrb, pstrb;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready;
  logic          psel, penable, pwrite, pready, pslverr;

  uart_axil_apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .chipset_clk(chipset_clk), .chipset_rst_n(chipset_rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial chipset_clk = 1'b0;
  always #5 chipset_clk = ~chipset_clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            waits;
    bit            err;
    logic [DW-1:0] rd;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_last_write;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge chipset_clk);
    #1;
  endtask

  function automatic txn_t mk(bit wr, logic [AW-1:0] addr, logic [DW-1:0] data,
                              logic [SW-1:0] strb, int waits, bit err, logic [DW-1:0] rd);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
    t.waits = waits; t.err = err; t.rd = rd;
    return t;
  endfunction

  function automatic txn_t rnd(bit wr);
    int r;
    r = int'($urandom_range(0, 9));
    return mk(wr, AW'($urandom), DW'($urandom), SW'($urandom), (r >= 8) ? TO + 1 + r : r % 4,
              bit'($urandom_range(0, 3) == 0), DW'($urandom));
  endfunction

  task automatic drive_aw(input txn_t t);
    chk("awready", 64'(s_axi_awready), 1);
    s_axi_awaddr = t.addr; s_axi_awvalid = 1'b1;
  endtask

  task automatic drive_w(input txn_t t);
    chk("wready", 64'(s_axi_wready), 1);
    s_axi_wdata = t.data; s_axi_wstrb = t.strb; s_axi_wvalid = 1'b1;
  endtask

  task automatic drive_ar(input txn_t t);
    chk("arready", 64'(s_axi_arready), 1);
    s_axi_araddr = t.addr; s_axi_arvalid = 1'b1;
  endtask

  task automatic clear_req();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
  endtask

  // Entered one cycle before the expected SETUP; runs the APB phases up to the response.
  task automatic serve_apb(input txn_t t, output logic [1:0] resp);
    bit timed;
    int acc;
    timed = (t.waits > TO);
    acc   = timed ? TO + 1 : t.waits + 1;
    resp  = (timed || t.err) ? 2'b10 : 2'b00;
    chk("pre_setup_psel", 64'(psel), 0);
    pslverr = t.err; prdata = t.rd; pready = 1'b0;
    step();
    chk("setup_phase", 64'({psel, penable}), 64'(2'b10));
    chk("setup_pwrite", 64'(pwrite), 64'(t.wr));
    chk("setup_paddr", 64'(paddr), 64'(t.addr));
    chk("setup_pwdata", 64'(pwdata), t.wr ? 64'(t.data) : 0);
    chk("setup_pstrb", 64'(pstrb), t.wr ? 64'(t.strb) : 0);
    step();
    for (int k = 0; k < acc; k++) begin
      chk("access_phase", 64'({psel, penable, s_axi_bvalid, s_axi_rvalid}), 64'(4'b1100));
      chk("access_paddr", 64'(paddr), 64'(t.addr));
      pready = (k == t.waits);
      step();
    end
    pready = 1'b0;
    m_last_write = t.wr;
    chk("resp_psel", 64'({psel, penable}), 0);
    if (t.wr) begin
      chk("bvalid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'(2'b10));
      chk("bresp", 64'(s_axi_bresp), 64'(resp));
    end else begin
      chk("rvalid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'(2'b01));
      chk("rresp", 64'(s_axi_rresp), 64'(resp));
      chk("rdata", 64'(s_axi_rdata), timed ? 0 : 64'(t.rd));
    end
  endtask

  task automatic finish_resp(input bit wr, input logic [1:0] resp, input int bp);
    for (int i = 0; i < bp; i++) begin
      chk("bp_valid", 64'(wr ? s_axi_bvalid : s_axi_rvalid), 1);
      chk("bp_resp", 64'(wr ? s_axi_bresp : s_axi_rresp), 64'(resp));
      chk("bp_quiet", 64'({s_axi_awready, s_axi_wready, s_axi_arready, psel}), 0);
      step();
    end
    if (wr) s_axi_bready = 1'b1; else s_axi_rready = 1'b1;
    step();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    chk("accepted", 64'({s_axi_bvalid, s_axi_rvalid}), 0);
  endtask

  task automatic serve(input txn_t t, input int bp);
    logic [1:0] r;
    serve_apb(t, r);
    finish_resp(t.wr, r, bp);
  endtask

  // Both requests were captured on the same edge; the model picks the order.
  task automatic serve_tie(input txn_t tw, input txn_t tr);
    if (!m_last_write) begin
      serve(tw, int'($urandom_range(0, 2)));
      serve(tr, int'($urandom_range(0, 2)));
    end else begin
      serve(tr, int'($urandom_range(0, 2)));
      serve(tw, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tw, tr;
    logic [1:0] r;
    int sel;
    chipset_rst_n = 1'b0; m_last_write = 1'b0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    clear_req(); s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    step(); step();
    chk("rst_ctrl", 64'({psel, penable, pwrite, s_axi_bvalid, s_axi_rvalid}), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwdata_pstrb", 64'({pwdata, pstrb}), 0);
    chk("rst_resp", 64'({s_axi_bresp, s_axi_rresp}), 0);
    chk("rst_rdata", 64'(s_axi_rdata), 0);
    chipset_rst_n = 1'b1;
    step();
    chk("post_rst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));

    // zero-wait write
    tw = mk(1, 13'h1004, 32'h41, 4'hF, 0, 0, 0);
    drive_aw(tw); drive_w(tw); step(); clear_req();
    serve(tw, 0);

    // read with two wait states
    tr = mk(0, 13'h0014, 0, 0, 2, 0, 32'h60);
    drive_ar(tr); step(); clear_req();
    serve(tr, 0);

    // W three cycles ahead of AW, AR alongside AW
    tw = mk(1, 13'h0a20, 32'hdeadbeef, 4'h5, 1, 0, 0);
    tr = mk(0, 13'h0a24, 0, 0, 0, 0, 32'h12345678);
    drive_w(tw); step(); clear_req();
    chk("w_held_wready", 64'(s_axi_wready), 0);
    for (int i = 0; i < 2; i++) begin
      chk("split_no_psel", 64'(psel), 0);
      step();
    end
    drive_aw(tw); drive_ar(tr); step(); clear_req();
    serve_tie(tw, tr);

    // slave error on a write
    tw = mk(1, 13'h0100, 32'h5a, 4'h1, 0, 1, 0);
    drive_aw(tw); drive_w(tw); step(); clear_req();
    serve(tw, 0);

    // tie after a write: read goes first
    tw = mk(1, 13'h0200, 32'h77, 4'hC, 0, 0, 0);
    tr = mk(0, 13'h0204, 0, 0, 1, 0, 32'h99);
    drive_aw(tw); drive_w(tw); drive_ar(tr); step(); clear_req();
    serve_tie(tw, tr);

    // timeout on a read
    tr = mk(0, 13'h1ffc, 0, 0, 50, 0, 32'hffffffff);
    drive_ar(tr); step(); clear_req();
    serve(tr, 0);

    // write response backpressure with an AR waiting
    tw = mk(1, 13'h0300, 32'hcafe, 4'hF, 0, 0, 0);
    tr = mk(0, 13'h0304, 0, 0, 0, 0, 32'hbeef);
    drive_aw(tw); drive_w(tw); step(); clear_req();
    serve_apb(tw, r);
    s_axi_araddr = tr.addr; s_axi_arvalid = 1'b1;
    finish_resp(1, r, 10);
    chk("bp_arready_after", 64'(s_axi_arready), 1);
    step(); clear_req();
    serve(tr, 0);

    // reset in the middle of ACCESS
    tw = mk(1, 13'h0400, 32'h1111, 4'hF, 50, 0, 0);
    drive_aw(tw); drive_w(tw); step(); clear_req();
    step(); step();
    chk("pre_reset_access", 64'({psel, penable}), 64'(2'b11));
    #2 chipset_rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({psel, penable, pwrite, s_axi_bvalid, s_axi_rvalid}), 0);
    chk("mid_rst_apb", 64'({paddr, pstrb}), 0);
    m_last_write = 1'b0;
    step(); step();
    chipset_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_resp", 64'({psel, s_axi_bvalid, s_axi_rvalid}), 0);
    end
    tw = mk(1, 13'h0408, 32'h2222, 4'h3, 0, 0, 0);
    drive_aw(tw); drive_w(tw); step(); clear_req();
    serve(tw, 1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      tw = rnd(1);
      tr = rnd(0);
      case (sel)
        0: begin
          drive_aw(tw); drive_w(tw); step(); clear_req();
          serve(tw, int'($urandom_range(0, 3)));
        end
        1: begin
          drive_ar(tr); step(); clear_req();
          serve(tr, int'($urandom_range(0, 3)));
        end
        2: begin
          drive_aw(tw); drive_w(tw); drive_ar(tr); step(); clear_req();
          serve_tie(tw, tr);
        end
        default: begin
          if ($urandom_range(0, 1) == 0) drive_w(tw); else drive_aw(tw);
          step(); clear_req();
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            chk("half_write_idle", 64'(psel), 0);
            step();
          end
          if (s_axi_wready) drive_w(tw); else drive_aw(tw);
          step(); clear_req();
          serve(tw, int'($urandom_range(0, 3)));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_axil_apb_bridge.md
# uart_axil_apb_bridge

Single-outstanding AXI4-Lite slave to APB (v2.0/APB4) master bridge. It consumes the system's 13-bit/32-bit `uart_axi_*` port and drives the APB-attached UART peripheral in the chipset clock domain. It adds per-channel request capture, fair read/write arbitration and a programmable APB wait-state timeout, so a hung peripheral always returns an error response instead of stalling the core.

## Interface
- `ADDR_WIDTH`, default 13: AXI-Lite and APB address width.
- `DATA_WIDTH`, default 32: data width; strobe width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS cycles without `pready`. A value of 0 disables the timeout.

Ports:
- `chipset_clk` in 1: the single clock; all logic is rising-edge.
- `chipset_rst_n` in 1: reset, asynchronous, active-low.
- `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in DATA_WIDTH, `s_axi_wstrb` in DATA_WIDTH/8, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out DATA_WIDTH, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `paddr` out ADDR_WIDTH, `psel` out 1, `penable` out 1, `pwrite` out 1, `pwdata` out DATA_WIDTH, `pstrb` out DATA_WIDTH/8: APB request.
- `prdata` in DATA_WIDTH, `pready` in 1, `pslverr` in 1: APB completion.

## Operation
- **Capture buffers.** Three one-entry holding registers (AW, W, AR), each with a `held` flag.
  - `s_axi_awready = (state==IDLE) & ~aw_held`. `wready` and `arready` follow the same rule with their own flags.
  - Readies depend only on registered state; there is no combinational valid-to-ready path.
- **Request pending rules.**
  - A write is pending when `aw_held & w_held`.
  - A read is pending when `ar_held`.
  - AW and W may arrive in any order or cycle.
- **FSM states:** IDLE, SETUP, ACCESS, WRESP, RRESP.
  - IDLE to SETUP when a request is pending. The grant goes to the pending type. If both are pending, grant goes to the type not granted last. `last_was_write` resets to 0, so write wins the first tie.
  - SETUP: `psel=1`, `penable=0`, `paddr`/`pwrite`/`pwdata`/`pstrb` driven from the granted buffer. For reads, `pstrb=0` and `pwdata=0`. Always goes to ACCESS next.
  - ACCESS: `psel=1`, `penable=1`, APB outputs held stable. Leaves on `pready=1` (completion) or on timeout.
    - Write exit: go to WRESP, clear `aw_held`/`w_held`, set `bresp = pslverr ? 2'b10 : 2'b00`.
    - Read exit: go to RRESP, clear `ar_held`, set `rdata=prdata` and `rresp = pslverr ? 2'b10 : 2'b00`.
  - Timeout: the wait counter clears on entering ACCESS and increments each ACCESS cycle with `pready=0`. When it reaches `TIMEOUT_CYCLES`, exit as above with resp `2'b10`, read data 0, and drop `psel`/`penable` in the next cycle. A `pready=1` in the expiry cycle wins and normal completion is reported.
  - WRESP: `bvalid=1` until `bready`, then IDLE.
  - RRESP: `rvalid=1` until `rready`, then IDLE.
- **No overlap.** No new APB transfer starts while a response is unaccepted.
  - During WRESP/RRESP all readies are 0. Buffers already held stay held.
- **Address and stability.**
  - `paddr` is the captured address unmodified; no alignment or decode is applied.
  - APB outputs outside SETUP/ACCESS keep their last values except `psel`/`penable`, which are 0.

## Timing
- **Reset values** (asynchronous on `chipset_rst_n=0`, released synchronously):
  - State is IDLE and all `held` flags are 0.
  - `psel`, `penable`, `pwrite`, `bvalid` and `rvalid` are 0.
  - `paddr`, `pwdata`, `pstrb`, `bresp`, `rresp` and `rdata` are 0.
  - The readies therefore read 1 from the first cycle after reset, provided that cycle is IDLE.
- **Reset mid-transfer** (SETUP/ACCESS/WRESP/RRESP): the transfer is abandoned with no response and `psel` drops immediately (asynchronously).
- **Zero-wait latency.**
  - Handshake at edge 0 gives SETUP after edge 1 and ACCESS after edge 2. `pready` sampled at edge 3 gives `bvalid`/`rvalid` after edge 3.
  - Response is 3 cycles after the last request handshake, plus one cycle per APB wait state.
- **Throughput.** Back-to-back: the response is accepted at edge n, IDLE is reached after edge n, and the next SETUP follows after edge n+1 if a request is already held.
- **Timeout bound.** ACCESS lasts at most `TIMEOUT_CYCLES+1` cycles.

## Test plan
- **Zero-wait write:** AW `0x1004` with W `0x00000041`/`0xF` in the same cycle; `pready` tied 1. Expect one SETUP cycle then one ACCESS cycle with `paddr=0x1004`, `pwrite=1`, `pwdata=0x41`, `pstrb=0xF`. Expect `bvalid` 3 cycles after the handshake with `bresp=00`.
- **Wait-state read:** AR `0x0014`; `pready` low for 2 ACCESS cycles, `prdata=0x60`. Expect `rvalid` 5 cycles after the handshake with `rdata=0x60`, `rresp=00`, and `pstrb=0`.
- **Split write plus arbitration:** W arrives 3 cycles before AW; AR arrives in the same cycle as AW. Expect the write first (reset tie-break), then the read. A second simultaneous write/read pair must grant the read first.
- **Errors:**
  - Write with `pslverr=1`/`pready=1`: expect `bresp=10`.
  - Read with `TIMEOUT_CYCLES=4` and `pready` never asserted: expect `psel` high for exactly 1 SETUP + 5 ACCESS cycles, then `rresp=10`, `rdata=0`.
- **Backpressure:** hold `bready=0` for 10 cycles. Expect `bvalid` stable and `bresp` stable. Expect all readies 0 and no `psel` despite a pending AR; the read starts 2 cycles after `bready` rises.
- **Reset mid-ACCESS:** assert `chipset_rst_n=0` while `psel=penable=1`. Expect all outputs at reset values immediately and no response after release. Then a fresh write completes normally.
